cci_mpf_fiu_mem_responder: RTL and testbench

FIU-side endpoint that answers CCI requests leaving the MPF pipeline: the responder for the MPF initiator path. It accepts c0 (read) and c1 (write) requests, backs them with a local line-addressed memory array, and returns c0 read data and c1 write acks after a fixed latency. It is used in MPF unit benches in place of the platform FIU, including multi-beat reads that exercise EOP detection and response sorting.

---
 rtl/cci_mpf_fiu_mem_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_cci_mpf_fiu_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_fiu_mem_responder.sv
// FIU-side CCI endpoint: line-addressed memory model answering c0 reads and c1 writes after a fixed latency.
// Optional build macro CCI_MPF_FIU_RSP_REVERSE_BEATS_EN issues multi-beat reads in descending cl_num order.
module cci_mpf_fiu_mem_responder #(
  parameter int MEM_ADDR_BITS  = 10,
  parameter int RSP_LATENCY    = 8,
  parameter int REQ_FIFO_DEPTH = 16,
  parameter int ALMFULL_SLACK  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         c0_req_valid,
  input  logic [41:0]  c0_req_addr,
  input  logic [1:0]   c0_req_cl_len,
  input  logic [15:0]  c0_req_mdata,
  input  logic         c1_req_valid,
  input  logic [41:0]  c1_req_addr,
  input  logic [511:0] c1_req_data,
  input  logic [15:0]  c1_req_mdata,
  output logic         c0_almfull,
  output logic         c1_almfull,
  output logic         c0_rsp_valid,
  output logic [511:0] c0_rsp_data,
  output logic [15:0]  c0_rsp_mdata,
  output logic [1:0]   c0_rsp_cl_num,
  output logic         c1_rsp_valid,
  output logic [15:0]  c1_rsp_mdata,
  output logic         err_sticky
);

  localparam int AW = MEM_ADDR_BITS;
  localparam int PW = $clog2(REQ_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(REQ_FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(REQ_FIFO_DEPTH - ALMFULL_SLACK);
`ifdef CCI_MPF_FIU_RSP_REVERSE_BEATS_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    cl_len;
    logic [15:0]   mdata;
  } rd_req_t;

  typedef enum logic {IDLE, BURST} rd_state_e;

  logic [511:0] mem [2**AW];

  // Request address bits above the memory index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c0_req_addr[41:AW], c1_req_addr[41:AW]};

  // ---------------- c0 request FIFO and read engine ----------------
  rd_req_t       rdf_mem [REQ_FIFO_DEPTH];
  logic [PW-1:0] rdf_wr_q, rdf_rd_q;
  logic [CW-1:0] rdf_cnt_q;
  rd_req_t       c0_in, head;
  logic          rdf_empty, rdf_full, head_valid, take_head, bypass;
  logic          rdf_push, rdf_pop, c0_drop, head_bad;
  logic [1:0]    head_last;

  rd_state_e     state_q;
  logic [AW-1:0] base_q;
  logic [15:0]   tag_q;
  logic [1:0]    len_q, beat_q;

  logic          iss_valid, burst_done;
  logic [1:0]    iss_k, iss_last;
  logic [AW-1:0] iss_base, iss_line;
  logic [15:0]   iss_tag;

  assign c0_in = {c0_req_addr[AW-1:0], c0_req_cl_len, c0_req_mdata};

  always_comb begin
    rdf_empty  = (rdf_cnt_q == '0);
    rdf_full   = (rdf_cnt_q == FULL_CNT);
    // An empty FIFO falls through so an idle engine issues in the arrival cycle.
    head       = rdf_empty ? c0_in : rdf_mem[rdf_rd_q];
    head_valid = !rdf_empty || c0_req_valid;
    take_head  = (state_q == IDLE) && head_valid;
    bypass     = take_head && rdf_empty;
    rdf_pop    = take_head && !rdf_empty;
    rdf_push   = c0_req_valid && !rdf_full && !bypass;
    c0_drop    = c0_req_valid && rdf_full;
    head_bad   = (head.cl_len == 2'd2);
    head_last  = (head.cl_len == 2'd1) ? 2'd1 : (head.cl_len == 2'd3) ? 2'd3 : 2'd0;

    iss_valid  = 1'b0;
    iss_k      = 2'd0;
    iss_base   = head.addr;
    iss_tag    = head.mdata;
    iss_last   = head_last;
    burst_done = 1'b0;
    if (state_q == BURST) begin
      iss_valid  = 1'b1;
      iss_k      = beat_q;
      iss_base   = base_q;
      iss_tag    = tag_q;
      iss_last   = len_q;
      burst_done = REV ? (beat_q == 2'd0) : (beat_q == len_q);
    end else if (take_head) begin
      iss_valid = 1'b1;
      iss_k     = REV ? head_last : 2'd0;
    end

    iss_line = iss_base;
    case (iss_last)
      2'd3:    iss_line[1:0] = iss_k;
      2'd1:    iss_line[0]   = iss_k[0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rdf_push) rdf_mem[rdf_wr_q] <= c0_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdf_wr_q  <= '0;
      rdf_rd_q  <= '0;
      rdf_cnt_q <= '0;
      state_q   <= IDLE;
      base_q    <= '0;
      tag_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
    end else begin
      if (rdf_push) rdf_wr_q <= rdf_wr_q + 1'b1;
      if (rdf_pop)  rdf_rd_q <= rdf_rd_q + 1'b1;
      rdf_cnt_q <= rdf_cnt_q + CW'(rdf_push) - CW'(rdf_pop);
      case (state_q)
        IDLE: if (take_head && head_last != 2'd0) begin
          state_q <= BURST;
          base_q  <= head.addr;
          tag_q   <= head.mdata;
          len_q   <= head_last;
          beat_q  <= REV ? head_last - 2'd1 : 2'd1;
        end
        BURST: begin
          if (burst_done) state_q <= IDLE;
          else            beat_q  <= REV ? beat_q - 2'd1 : beat_q + 2'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- c1 write path and ack FIFO ----------------
  logic [15:0]   wf_mem [REQ_FIFO_DEPTH];
  logic [PW-1:0] wf_wr_q, wf_rd_q;
  logic [CW-1:0] wf_cnt_q;
  logic          wf_empty, wf_full, c1_accept, c1_drop, wf_push, wf_pop, ack_valid;
  logic [15:0]   ack_tag;

  always_comb begin
    wf_empty  = (wf_cnt_q == '0);
    wf_full   = (wf_cnt_q == FULL_CNT);
    c1_accept = c1_req_valid && !wf_full;
    c1_drop   = c1_req_valid && wf_full;
    wf_pop    = !wf_empty;
    wf_push   = c1_accept && !wf_empty;
    ack_valid = !wf_empty || c1_req_valid;
    ack_tag   = wf_empty ? c1_req_mdata : wf_mem[wf_rd_q];
  end

  always_ff @(posedge clk) begin
    if (reset_n && c1_accept) mem[c1_req_addr[AW-1:0]] <= c1_req_data;
    if (wf_push) wf_mem[wf_wr_q] <= c1_req_mdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wf_wr_q  <= '0;
      wf_rd_q  <= '0;
      wf_cnt_q <= '0;
    end else begin
      if (wf_push) wf_wr_q <= wf_wr_q + 1'b1;
      if (wf_pop)  wf_rd_q <= wf_rd_q + 1'b1;
      wf_cnt_q <= wf_cnt_q + CW'(wf_push) - CW'(wf_pop);
    end
  end

  // ---------------- latency pipes, almfull, error ----------------
  logic         p0_v_q    [RSP_LATENCY];
  logic [511:0] p0_data_q [RSP_LATENCY];
  logic [15:0]  p0_tag_q  [RSP_LATENCY];
  logic [1:0]   p0_k_q    [RSP_LATENCY];
  logic         p1_v_q    [RSP_LATENCY];
  logic [15:0]  p1_tag_q  [RSP_LATENCY];
  logic         c0_af_q, c1_af_q, err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < RSP_LATENCY; i++) begin
        p0_v_q[i]    <= 1'b0;
        p0_data_q[i] <= '0;
        p0_tag_q[i]  <= '0;
        p0_k_q[i]    <= '0;
        p1_v_q[i]    <= 1'b0;
        p1_tag_q[i]  <= '0;
      end
      c0_af_q <= 1'b0;
      c1_af_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      p0_v_q[0]    <= iss_valid;
      p0_data_q[0] <= mem[iss_line];
      p0_tag_q[0]  <= iss_tag;
      p0_k_q[0]    <= iss_k;
      p1_v_q[0]    <= ack_valid;
      p1_tag_q[0]  <= ack_tag;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        p0_v_q[i]    <= p0_v_q[i-1];
        p0_data_q[i] <= p0_data_q[i-1];
        p0_tag_q[i]  <= p0_tag_q[i-1];
        p0_k_q[i]    <= p0_k_q[i-1];
        p1_v_q[i]    <= p1_v_q[i-1];
        p1_tag_q[i]  <= p1_tag_q[i-1];
      end
      c0_af_q <= (rdf_cnt_q >= AF_CNT);
      c1_af_q <= (wf_cnt_q >= AF_CNT);
      err_q   <= err_q | c0_drop | c1_drop | (take_head && head_bad);
    end
  end

  assign c0_almfull    = c0_af_q;
  assign c1_almfull    = c1_af_q;
  assign c0_rsp_valid  = p0_v_q[RSP_LATENCY-1];
  assign c0_rsp_data   = p0_data_q[RSP_LATENCY-1];
  assign c0_rsp_mdata  = p0_tag_q[RSP_LATENCY-1];
  assign c0_rsp_cl_num = p0_k_q[RSP_LATENCY-1];
  assign c1_rsp_valid  = p1_v_q[RSP_LATENCY-1];
  assign c1_rsp_mdata  = p1_tag_q[RSP_LATENCY-1];
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_cci_mpf_fiu_mem_responder.sv
// Self-checking bench for cci_mpf_fiu_mem_responder: vector table plus scoreboard queues of expected responses.
module tb_cci_mpf_fiu_mem_responder;
  localparam int L = 8;
`ifdef CCI_MPF_FIU_RSP_REVERSE_BEATS_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         c0_req_valid, c1_req_valid;
  logic [41:0]  c0_req_addr, c1_req_addr;
  logic [1:0]   c0_req_cl_len;
  logic [15:0]  c0_req_mdata, c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         c0_almfull, c1_almfull, c0_rsp_valid, c1_rsp_valid, err_sticky;
  logic [511:0] c0_rsp_data;
  logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
  logic [1:0]   c0_rsp_cl_num;

  cci_mpf_fiu_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
    .c0_req_cl_len(c0_req_cl_len), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr),
    .c1_req_data(c1_req_data), .c1_req_mdata(c1_req_mdata),
    .c0_almfull(c0_almfull), .c1_almfull(c1_almfull),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_cl_num(c0_rsp_cl_num),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [511:0] data;
    logic [15:0]  tag;
    logic [1:0]   k;
  } rsp_t;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [41:0]  addr;
    logic [1:0]   cl_len;
    logic [15:0]  wtag;
    logic [15:0]  rtag;
    logic [511:0] wdata;
    bit           exp_err;
  } vec_t;

  rsp_t         q0[$];
  rsp_t         q1[$];
  rsp_t         e0, e1;
  logic [511:0] model_mem [int];
  bit           mon_en = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;
  vec_t         vecs[16];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wr, bit rd, logic [41:0] a, logic [1:0] l,
                              logic [15:0] wt, logic [15:0] rt, logic [511:0] d, bit e);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.cl_len = l;
    v.wtag = wt; v.rtag = rt; v.wdata = d; v.exp_err = e;
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en && c0_rsp_valid) begin
      if (q0.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL c0_unexpected: got beat tag %0h at cycle %0d expected none", c0_rsp_mdata, cyc);
      end else begin
        e0 = q0.pop_front();
        check("c0_cycle", cyc, e0.cyc);
        check("c0_data", c0_rsp_data, e0.data);
        check("c0_mdata", c0_rsp_mdata, e0.tag);
        check("c0_cl_num", c0_rsp_cl_num, e0.k);
      end
    end
    if (mon_en && c1_rsp_valid) begin
      if (q1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL c1_unexpected: got ack tag %0h at cycle %0d expected none", c1_rsp_mdata, cyc);
      end else begin
        e1 = q1.pop_front();
        check("c1_cycle", cyc, e1.cyc);
        check("c1_mdata", c1_rsp_mdata, e1.tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats of a read whose first beat issues in cycle start.
  task automatic push_read(input logic [41:0] addr, input logic [1:0] len,
                           input logic [15:0] tag, input int start);
    int   nb;
    int   line;
    rsp_t r;
    nb = (len == 2'd3) ? 4 : (len == 2'd1) ? 2 : 1;
    for (int j = 0; j < nb; j++) begin
      r.k  = REV ? 2'(nb - 1 - j) : 2'(j);
      line = int'(addr[9:0]);
      if (nb == 4) line = (line & ~3) | int'(r.k);
      if (nb == 2) line = (line & ~1) | int'(r.k[0]);
      r.cyc  = start + L + j;
      r.data = model_mem[line];
      r.tag  = tag;
      q0.push_back(r);
    end
  endtask

  task automatic drive(input vec_t v);
    rsp_t r;
    if (v.rd) begin
      push_read(v.addr, v.cl_len, v.rtag, cyc);
      c0_req_valid = 1'b1; c0_req_addr = v.addr; c0_req_cl_len = v.cl_len; c0_req_mdata = v.rtag;
    end
    if (v.wr) begin
      model_mem[int'(v.addr[9:0])] = v.wdata;
      r.cyc = cyc + L; r.data = '0; r.tag = v.wtag; r.k = 2'd0;
      q1.push_back(r);
      c1_req_valid = 1'b1; c1_req_addr = v.addr; c1_req_data = v.wdata; c1_req_mdata = v.wtag;
    end
    tick();
    c0_req_valid = 1'b0;
    c1_req_valid = 1'b0;
  endtask

  initial begin
    int   stray;
    bit   found;
    int   c;
    vec_t va, vb;

    vecs[0] = mk(1, 0, 42'h10, 2'd0, 16'h1, 16'h0, {64{8'hA5}}, 0);
    vecs[1] = mk(0, 1, 42'h10, 2'd0, 16'h0, 16'h2, '0, 0);
    for (int i = 0; i < 4; i++)
      vecs[2+i] = mk(1, 0, 42'h20 + 42'(i), 2'd0, 16'h20 + 16'(i), 16'h0,
                     {16{32'hD0D0_0020 + 32'(i)}}, 0);
    vecs[6]  = mk(0, 1, 42'h20, 2'd3, 16'h0, 16'h7, '0, 0);
    vecs[7]  = mk(0, 1, 42'h23, 2'd1, 16'h0, 16'h8, '0, 0);
    vecs[8]  = mk(0, 1, 42'h21, 2'd3, 16'h0, 16'h9, '0, 0);
    vecs[9]  = mk(1, 0, 42'h30, 2'd0, 16'h30, 16'h0, {16{32'h0BAD_0030}}, 0);
    vecs[10] = mk(1, 1, 42'h30, 2'd0, 16'h31, 16'h32, {16{32'h600D_0030}}, 0);
    vecs[11] = mk(0, 1, 42'h30, 2'd0, 16'h0, 16'h33, '0, 0);
    vecs[12] = mk(1, 0, 42'h3_0000_0040, 2'd0, 16'h40, 16'h0, {16{32'h4040_4040}}, 0);
    vecs[13] = mk(0, 1, 42'h40, 2'd0, 16'h0, 16'h41, '0, 0);
    vecs[14] = mk(0, 1, 42'h10, 2'd2, 16'h0, 16'h99, '0, 1);
    vecs[15] = mk(0, 1, 42'h20, 2'd0, 16'h0, 16'h9A, '0, 1);

    reset_n = 1'b0;
    c0_req_valid = 1'b0; c0_req_addr = '0; c0_req_cl_len = '0; c0_req_mdata = '0;
    c1_req_valid = 1'b0; c1_req_addr = '0; c1_req_data = '0; c1_req_mdata = '0;
    repeat (3) tick();
    check("rst_c0_valid", c0_rsp_valid, 1'b0);
    check("rst_c1_valid", c1_rsp_valid, 1'b0);
    check("rst_c0_almfull", c0_almfull, 1'b0);
    check("rst_c1_almfull", c1_almfull, 1'b0);
    check("rst_err", err_sticky, 1'b0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      repeat (4) tick();
      check("err_after_vec", err_sticky, vecs[i].exp_err);
    end

    // Write then read the same line on the very next cycle: new data.
    va = mk(1, 0, 42'h30, 2'd0, 16'h50, 16'h0, {16{32'h7777_0030}}, 0);
    vb = mk(0, 1, 42'h30, 2'd0, 16'h0, 16'h51, '0, 0);
    drive(va);
    drive(vb);
    repeat (4) tick();

    // Back-to-back packets: second read queues behind a 4-beat burst with no gap.
    c = cyc;
    push_read(42'h20, 2'd3, 16'h60, c);
    c0_req_valid = 1'b1; c0_req_addr = 42'h20; c0_req_cl_len = 2'd3; c0_req_mdata = 16'h60;
    tick();
    push_read(42'h10, 2'd0, 16'h61, c + 4);
    c0_req_addr = 42'h10; c0_req_cl_len = 2'd0; c0_req_mdata = 16'h61;
    tick();
    c0_req_valid = 1'b0;
    repeat (L + 8) tick();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("err_cleared_by_reset", err_sticky, 1'b0);

    // Flood the read channel with 4-line reads: almfull, then overflow.
    mon_en = 1'b0;
    q0.delete();
    q1.delete();
    check("almfull_low_start", c0_almfull, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      c0_req_valid = 1'b1; c0_req_addr = 42'h10; c0_req_cl_len = 2'd3; c0_req_mdata = 16'(i);
      tick();
      if (c0_almfull) found = 1'b1;
    end
    check("almfull_rise", found, 1'b1);
    check("err_before_full", err_sticky, 1'b0);
    repeat (10) tick();
    c0_req_valid = 1'b0;
    check("err_on_overflow", err_sticky, 1'b1);
    check("almfull_held", c0_almfull, 1'b1);
    check("c1_almfull_idle", c1_almfull, 1'b0);

    // One-cycle reset while the engine is mid-burst.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_c0_valid", c0_rsp_valid, 1'b0);
    check("mid_rst_c0_data", c0_rsp_data, '0);
    check("mid_rst_c0_mdata", c0_rsp_mdata, 16'h0);
    check("mid_rst_cl_num", c0_rsp_cl_num, 2'd0);
    check("mid_rst_c1_valid", c1_rsp_valid, 1'b0);
    check("mid_rst_almfull", c0_almfull, 1'b0);
    check("mid_rst_err", err_sticky, 1'b0);
    stray = 0;
    for (int i = 0; i < 3 * L; i++) begin
      tick();
      if (c0_rsp_valid || c1_rsp_valid) stray++;
    end
    check("no_rsp_after_reset", stray, 0);

    // Memory survives reset.
    mon_en = 1'b1;
    drive(mk(0, 1, 42'h20, 2'd3, 16'h0, 16'h55, '0, 0));
    drive(mk(0, 0, 42'h0, 2'd0, 16'h0, 16'h0, '0, 0));
    repeat (4) tick();
    drive(mk(0, 1, 42'h10, 2'd0, 16'h0, 16'h56, '0, 0));
    repeat (L + 6) tick();
    check("q0_final_empty", q0.size(), 0);
    check("q1_final_empty", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
